// File: rtl/demux_5ch_10bit_buf.sv
// demux_5ch_10bit_buf
// Steers one word stream to one of five buffered output channels (a..e).
// Each channel has a one-entry holding register with a valid/ready handshake,
// so each sink can stall on its own.
// A word whose select is 5..7 is accepted, dropped, and flagged on err_sel
// for one cycle.
// Optional feature: define DEMUX_DROP_CNT_EN to add a saturating drop_cnt
// output that counts the dropped words.
module demux_5ch_10bit_buf #(
    parameter int word_size = 10,
    parameter int cnt_size  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [word_size-1:0] data_in,
    input  logic [2:0]           sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [word_size-1:0] data_a,
    output logic [word_size-1:0] data_b,
    output logic [word_size-1:0] data_c,
    output logic [word_size-1:0] data_d,
    output logic [word_size-1:0] data_e,
    output logic [4:0]           out_valid,
    input  logic [4:0]           out_ready,
    output logic                 err_sel
`ifdef DEMUX_DROP_CNT_EN
    ,
    output logic [cnt_size-1:0]  drop_cnt
`endif
);

    localparam int num_ch = 5;

    logic [word_size-1:0] data_bus [num_ch];
    logic [num_ch-1:0]    valid_bus;
    logic [num_ch-1:0]    chan_free;
    logic [num_ch-1:0]    load_sel;
    logic                 sel_ok;
    logic                 in_fire;
    logic                 err_sel_reg;

    // Select codes 5..7 do not address any channel.
    assign sel_ok  = (sel < 3'd5);
    assign in_fire = in_valid & in_ready;

    // in_ready follows the addressed channel only. It never looks at
    // in_valid, so a sink can never form a loop through the handshake.
    always_comb begin
        in_ready = 1'b1;
        case (sel)
            3'd0:    in_ready = chan_free[0];
            3'd1:    in_ready = chan_free[1];
            3'd2:    in_ready = chan_free[2];
            3'd3:    in_ready = chan_free[3];
            3'd4:    in_ready = chan_free[4];
            default: in_ready = 1'b1;
        endcase
    end

    for (genvar gi = 0; gi < num_ch; gi++) begin : g_ch
        logic                 ch_valid_reg;
        logic [word_size-1:0] ch_data_reg;

        // A channel can take a word when it is empty, or when it drains in
        // the same cycle. The second case gives full-rate back-to-back hand-off.
        assign chan_free[gi] = ~ch_valid_reg | out_ready[gi];
        assign load_sel[gi]  = in_fire & (sel == 3'(gi));

        // Holding register: a load takes priority over a drain. After a drain
        // the data stays put, so consumers must qualify data with out_valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ch_valid_reg <= 1'b0;
                ch_data_reg  <= '0;
            end else if (load_sel[gi]) begin
                ch_valid_reg <= 1'b1;
                ch_data_reg  <= data_in;
            end else if (ch_valid_reg && out_ready[gi]) begin
                ch_valid_reg <= 1'b0;
            end
        end

        assign valid_bus[gi] = ch_valid_reg;
        assign data_bus[gi]  = ch_data_reg;
    end

    assign out_valid = valid_bus;
    assign data_a    = data_bus[0];
    assign data_b    = data_bus[1];
    assign data_c    = data_bus[2];
    assign data_d    = data_bus[3];
    assign data_e    = data_bus[4];

    // One pulse per dropped word. Back-to-back drops give back-to-back pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_reg <= 1'b0;
        end else begin
            err_sel_reg <= in_fire & ~sel_ok;
        end
    end

    assign err_sel = err_sel_reg;

`ifdef DEMUX_DROP_CNT_EN
    logic [cnt_size-1:0] drop_cnt_reg;

    // Counts dropped words and saturates at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (in_fire && !sel_ok && !(&drop_cnt_reg)) begin
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_demux_5ch_10bit_buf.sv
// Directed testbench for demux_5ch_10bit_buf.
// Inputs are driven on the falling edge. Combinational in_ready is checked
// 1 time unit later, and registered outputs are checked 1 time unit after
// the rising edge.
module tb_demux_5ch_10bit_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] data_in;
    logic [2:0] sel;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] data_a, data_b, data_c, data_d, data_e;
    logic [4:0] out_valid;
    logic [4:0] out_ready;
    logic       err_sel;
`ifdef DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_5ch_10bit_buf dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .data_c    (data_c),
        .data_d    (data_d),
        .data_e    (data_e),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sel   (err_sel)
`ifdef DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    // Applies inputs on the falling edge and lets combinational logic settle.
    task automatic drive(input logic v, input logic [2:0] s, input logic [9:0] d);
        @(negedge clk);
        in_valid = v;
        sel      = s;
        data_in  = d;
        #1;
    endtask

    // Advances past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; sel = 3'd0; data_in = '0; out_ready = '0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 5'b0) begin errors++; $display("FAIL reset_valid got %b want %b", out_valid, 5'b0); end
        checks++;
        if ({data_a, data_b, data_c, data_d, data_e} !== 50'b0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h %h want 0", data_a, data_b, data_c, data_d, data_e);
        end
        checks++;
        if (err_sel !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_sel); end
`ifdef DEMUX_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", drop_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: done");
    endtask

    task automatic test_single();
        out_ready = 5'b11111;
        drive(1'b1, 3'd2, 10'h155);
        tick();
        checks++;
        if (out_valid !== 5'b00100) begin errors++; $display("FAIL single_valid got %b want %b", out_valid, 5'b00100); end
        checks++;
        if (data_c !== 10'h155) begin errors++; $display("FAIL single_data got %h want %h", data_c, 10'h155); end
        drive(1'b0, 3'd0, 10'h000);
        tick();
        checks++;
        if (out_valid !== 5'b00000) begin errors++; $display("FAIL single_drain got %b want %b", out_valid, 5'b0); end
        checks++;
        if (data_c !== 10'h155) begin errors++; $display("FAIL single_hold got %h want %h", data_c, 10'h155); end
        $display("single: sel=2 word=155 data_c=%h", data_c);
    endtask

    task automatic test_stall();
        out_ready = 5'b00000;
        drive(1'b1, 3'd0, 10'h001);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_first_rdy got %b want 1", in_ready); end
        tick();
        drive(1'b1, 3'd0, 10'h002);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_block_rdy got %b want 0", in_ready); end
        tick();
        checks++;
        if (out_valid[0] !== 1'b1 || data_a !== 10'h001) begin
            errors++; $display("FAIL stall_held got v=%b d=%h want v=1 d=001", out_valid[0], data_a);
        end
        @(negedge clk);
        out_ready = 5'b00001;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_rdy got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid[0] !== 1'b1 || data_a !== 10'h002) begin
            errors++; $display("FAIL stall_handoff got v=%b d=%h want v=1 d=002", out_valid[0], data_a);
        end
        @(negedge clk);
        out_ready = 5'b00000;
        in_valid  = 1'b0;
        $display("stall: channel a handoff data_a=%h", data_a);
    endtask

    task automatic test_independence();
        logic [2:0] sels  [3];
        logic [9:0] words [3];
        sels[0] = 3'd1; sels[1] = 3'd3; sels[2] = 3'd4;
        words[0] = 10'h011; words[1] = 10'h033; words[2] = 10'h044;
        out_ready = 5'b11110;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, sels[i], words[i]);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_rdy%0d got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid[sels[i]] !== 1'b1) begin errors++; $display("FAIL indep_valid%0d got %b want 1", i, out_valid[sels[i]]); end
            checks++;
            if (out_valid[0] !== 1'b1 || data_a !== 10'h002) begin
                errors++; $display("FAIL indep_a%0d got v=%b d=%h want v=1 d=002", i, out_valid[0], data_a);
            end
            $display("indep: sel=%0d word=%h", sels[i], words[i]);
        end
        checks++;
        if (data_b !== 10'h011 || data_d !== 10'h033 || data_e !== 10'h044) begin
            errors++; $display("FAIL indep_data got b=%h d=%h e=%h want 011 033 044", data_b, data_d, data_e);
        end
        drive(1'b0, 3'd0, 10'h000);
        tick();
        checks++;
        if (out_valid !== 5'b00001) begin errors++; $display("FAIL indep_drain got %b want %b", out_valid, 5'b00001); end
    endtask

    task automatic test_invalid();
        drive(1'b1, 3'd6, 10'h3FF);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL inv_rdy got %b want 1", in_ready); end
        tick();
        checks++;
        if (out_valid !== 5'b00001) begin errors++; $display("FAIL inv_valid got %b want %b", out_valid, 5'b00001); end
        checks++;
        if (err_sel !== 1'b1) begin errors++; $display("FAIL inv_err got %b want 1", err_sel); end
`ifdef DEMUX_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd1) begin errors++; $display("FAIL inv_cnt1 got %0d want 1", drop_cnt); end
`endif
        drive(1'b0, 3'd6, 10'h3FF);
        tick();
        checks++;
        if (err_sel !== 1'b0) begin errors++; $display("FAIL inv_pulse_end got %b want 0", err_sel); end
        drive(1'b1, 3'd5, 10'h005);
        tick();
        checks++;
        if (err_sel !== 1'b1) begin errors++; $display("FAIL inv_consec1 got %b want 1", err_sel); end
        drive(1'b1, 3'd7, 10'h007);
        tick();
        checks++;
        if (err_sel !== 1'b1) begin errors++; $display("FAIL inv_consec2 got %b want 1", err_sel); end
        checks++;
        if (out_valid !== 5'b00001 || data_a !== 10'h002) begin
            errors++; $display("FAIL inv_untouched got v=%b a=%h want 00001 002", out_valid, data_a);
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'd6, 10'h3FF);
            tick();
        end
`ifdef DEMUX_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd255) begin errors++; $display("FAIL inv_sat got %0d want 255", drop_cnt); end
`endif
        drive(1'b0, 3'd0, 10'h000);
        tick();
        $display("invalid: dropped 303 words");
    endtask

    task automatic test_async_reset();
        out_ready = 5'b00000;
        drive(1'b1, 3'd1, 10'h0AA);
        tick();
        drive(1'b1, 3'd4, 10'h0BB);
        tick();
        drive(1'b0, 3'd0, 10'h000);
        checks++;
        if (data_b !== 10'h0AA || data_e !== 10'h0BB) begin
            errors++; $display("FAIL arst_load got b=%h e=%h want 0AA 0BB", data_b, data_e);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 5'b0) begin errors++; $display("FAIL arst_valid got %b want 0", out_valid); end
        checks++;
        if (data_b !== 10'h000 || data_e !== 10'h000) begin
            errors++; $display("FAIL arst_data got b=%h e=%h want 000 000", data_b, data_e);
        end
`ifdef DEMUX_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt got %0d want 0", drop_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        $display("async_reset: cleared before clock edge");
    endtask

    task automatic test_back_to_back();
        logic [9:0] w;
        out_ready = 5'b01000;
        for (int i = 0; i < 4; i++) begin
            w = 10'h100 + 10'(i);
            drive(1'b1, 3'd3, w);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d got %b want 1", i, in_ready); end
            tick();
            checks++;
            if (out_valid[3] !== 1'b1 || data_d !== w) begin
                errors++; $display("FAIL b2b_data%0d got v=%b d=%h want v=1 d=%h", i, out_valid[3], data_d, w);
            end
            $display("b2b: word %0d data_d=%h", i, data_d);
        end
        drive(1'b0, 3'd0, 10'h000);
        tick();
        checks++;
        if (out_valid !== 5'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_independence();
        test_invalid();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
